io_input_conditioner: RTL and testbench

Conditions the board's raw push-button and 16 slide switches before the data-memory MMIO read path uses them.
- Drives that path's `buttonOn` and `io_rdata_switch` inputs.
- Synchronises the raw pins, debounces the button with an FSM, and filters switch glitches with a stability counter.
- Turns a debounced button press into a sticky flag that the CPU clears by reading the button address.
- All logic runs on posedge clk, so outputs are settled before the data memory samples them on negedge.

---
 rtl/io_input_conditioner_if.sv | 31 +++
 rtl/io_input_conditioner.sv | 159 +++++++++++++++
 tb/tb_io_input_conditioner.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_input_conditioner_if.sv
// Bundle between the board pins / MMIO read path and io_input_conditioner.
//
// Signalling: btn_rd is a single-cycle strobe with no ready; the conditioner
// always accepts it on the next posedge. All outputs are registered levels
// that the consumer may sample at any time. There is no valid/ready pair
// here: every signal is either a raw pin, a one-cycle strobe, or a level.
//
// dbg_state exposes the button FSM state:
// 0 = IDLE_LOW, 1 = WAIT_HIGH, 2 = IDLE_HIGH, 3 = WAIT_LOW.
interface io_input_conditioner_if;
    logic        btn_raw;
    logic [15:0] sw_raw;
    logic        btn_rd;
    logic        button_on;
    logic        btn_level;
    logic [15:0] io_rdata_switch;
    logic [7:0]  press_count;
    logic [1:0]  dbg_state;

    // Board / CPU side: drives pins and the read strobe, observes results.
    modport master (
        output btn_raw, sw_raw, btn_rd,
        input  button_on, btn_level, io_rdata_switch, press_count, dbg_state
    );

    // Conditioner side.
    modport slave (
        input  btn_raw, sw_raw, btn_rd,
        output button_on, btn_level, io_rdata_switch, press_count, dbg_state
    );
endinterface

// File: rtl/io_input_conditioner.sv
// Conditions the raw push-button and 16 slide switches for the MMIO read path.
// - Two-flop synchronisers on every raw pin.
// - Button: four-state debounce FSM, sticky press flag cleared by btn_rd.
// - Switches: whole-vector stability filter, published atomically.
// Optional feature macro: IO_PRESS_COUNT_EN (accepted-press counter on
// press_count; when undefined press_count is tied to zero).
// DEBOUNCE_CYCLES and SW_STABLE_CYCLES must be >= 2, and
// 2**CNT_W must exceed both of them.
module io_input_conditioner #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int SW_STABLE_CYCLES = 1000000,
    parameter int CNT_W            = 20
) (
    input logic                   clk,
    input logic                   rst,
    io_input_conditioner_if.slave io
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } btn_state_t;

    logic             b_s1, b_s2;
    logic [15:0]      s_s1, s_s2;

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             on_q;

    logic [15:0]      sw_prev;
    logic [CNT_W-1:0] sw_cnt;
    logic [15:0]      sw_out;

    // Two-flop synchronisers; nothing sits between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
            s_s1 <= 16'h0000;
            s_s2 <= 16'h0000;
        end else begin
            b_s1 <= io.btn_raw;
            b_s2 <= b_s1;
            s_s1 <= io.sw_raw;
            s_s2 <= s_s1;
        end
    end

    // Debounce FSM with registered level and sticky press flag. The clear
    // from btn_rd is written first so that a same-edge set overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            level_q <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            if (io.btn_rd) begin
                on_q <= 1'b0;
            end
            case (state)
                IDLE_LOW: begin
                    if (b_s2) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!b_s2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= IDLE_HIGH;
                        level_q <= 1'b1;
                        on_q    <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!b_s2) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (b_s2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= IDLE_LOW;
                        level_q <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef IO_PRESS_COUNT_EN
    logic       accept_rise;
    logic [7:0] press_cnt_q;

    // Same condition that sets the press flag.
    assign accept_rise = (state == WAIT_HIGH) && b_s2 && (cnt == DEB_LAST);

    // Accepted-press counter; wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_cnt_q <= 8'd0;
        end else if (accept_rise) begin
            press_cnt_q <= press_cnt_q + 8'd1;
        end
    end

    assign io.press_count = press_cnt_q;
`else
    assign io.press_count = 8'd0;
`endif

    // Switch stability filter: any bit change restarts the window for the
    // whole vector, and the vector is published in one assignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_prev <= 16'h0000;
            sw_cnt  <= '0;
            sw_out  <= 16'h0000;
        end else begin
            sw_prev <= s_s2;
            if (s_s2 != sw_prev) begin
                sw_cnt <= '0;
            end else if (sw_cnt == SW_LAST) begin
                sw_out <= s_s2;
            end else if (sw_cnt != CNT_MAX) begin
                sw_cnt <= sw_cnt + CNT_ONE;
            end
        end
    end

    assign io.button_on       = on_q;
    assign io.btn_level       = level_q;
    assign io.io_rdata_switch = sw_out;
    assign io.dbg_state       = state;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with short debounce / stability windows.
// The reference model keeps a history of raw pin samples: a level change is
// accepted once D+1 consecutive synchronised samples disagree with the current
// level, and a switch vector is published once S+1 consecutive samples match.
module tb_io_input_conditioner;

    localparam int D  = 4;
    localparam int S  = 4;
    localparam int CW = 20;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    io_input_conditioner_if io();

    io_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SW_STABLE_CYCLES(S),
        .CNT_W           (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          bh[$];
    logic [15:0] sh[$];
    bit          m_level;
    bit          m_on;
    bit          m_rise;
    logic [15:0] m_sw;
    logic [7:0]  m_pc;

    task automatic model_reset();
        bh = {};
        sh = {};
        for (int i = 0; i < D + 3; i++) bh.push_back(1'b0);
        for (int i = 0; i < S + 3; i++) sh.push_back(16'h0000);
        m_level = 1'b0;
        m_on    = 1'b0;
        m_rise  = 1'b0;
        m_sw    = 16'h0000;
        m_pc    = 8'd0;
    endtask

    // Advance one clock edge, update the model from inputs present at the edge.
    task automatic tick();
        bit          all_opp;
        bit          all_eq;
        bit          rd;
        logic [15:0] cand;
        @(posedge clk);
        rd = io.btn_rd;
        bh.push_back(io.btn_raw);
        void'(bh.pop_front());
        sh.push_back(io.sw_raw);
        void'(sh.pop_front());
        all_opp = 1'b1;
        for (int j = 2; j <= D + 2; j++)
            if (bh[bh.size() - 1 - j] == m_level) all_opp = 1'b0;
        m_rise = all_opp && !m_level;
        if (all_opp) m_level = !m_level;
        if (m_rise) begin
            m_on = 1'b1;
`ifdef IO_PRESS_COUNT_EN
            m_pc = m_pc + 8'd1;
`endif
        end else if (rd) begin
            m_on = 1'b0;
        end
        cand   = sh[sh.size() - 3];
        all_eq = 1'b1;
        for (int j = 2; j <= S + 2; j++)
            if (sh[sh.size() - 1 - j] != cand) all_eq = 1'b0;
        if (all_eq) m_sw = cand;
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        io.btn_raw = 1'b0;
        io.sw_raw  = 16'h0000;
        io.btn_rd  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (io.button_on !== 1'b0) begin errors++; $display("FAIL reset_button_on: got %b expected 0", io.button_on); end
        checks++;
        if (io.btn_level !== 1'b0) begin errors++; $display("FAIL reset_btn_level: got %b expected 0", io.btn_level); end
        checks++;
        if (io.io_rdata_switch !== 16'h0000) begin errors++; $display("FAIL reset_switch: got %h expected 0000", io.io_rdata_switch); end
        checks++;
        if (io.press_count !== 8'd0) begin errors++; $display("FAIL reset_press_count: got %0d expected 0", io.press_count); end
        checks++;
        if (io.dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", io.dbg_state); end
    endtask

    // Raise the button; first sample is tick 1, acceptance at tick D+3.
    task automatic test_debounce_latency();
        io.btn_raw = 1'b1;
        for (int t = 1; t <= D + 3; t++) begin
            tick();
            checks++;
            if (io.btn_level !== (t == D + 3)) begin
                errors++; $display("FAIL latency_level t=%0d: got %b expected %b", t, io.btn_level, (t == D + 3));
            end
        end
        checks++;
        if (io.button_on !== 1'b1) begin errors++; $display("FAIL latency_button_on: got %b expected 1", io.button_on); end
        checks++;
`ifdef IO_PRESS_COUNT_EN
        if (io.press_count !== 8'd1) begin errors++; $display("FAIL latency_press_count: got %0d expected 1", io.press_count); end
`else
        if (io.press_count !== 8'd0) begin errors++; $display("FAIL latency_press_count: got %0d expected 0", io.press_count); end
`endif
    endtask

    task automatic wait_level(input bit lvl, input string tag);
        bit ok;
        ok = (m_level == lvl);
        for (int n = 0; n < 40 && !ok; n++) begin
            tick();
            ok = (m_level == lvl);
        end
        checks++;
        if (io.btn_level !== lvl) begin
            errors++; $display("FAIL %s_level_wait: got %b expected %b", tag, io.btn_level, lvl);
        end
    endtask

    task automatic test_glitch();
        io.btn_raw = 1'b0;
        wait_level(1'b0, "glitch");
        io.btn_rd = 1'b1;
        tick();
        io.btn_rd = 1'b0;
        io.btn_raw = 1'b1;
        repeat (3) tick();
        io.btn_raw = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            checks++;
            if (io.btn_level !== 1'b0) begin errors++; $display("FAIL glitch_level t=%0d: got %b expected 0", t, io.btn_level); end
        end
        checks++;
        if (io.button_on !== 1'b0) begin errors++; $display("FAIL glitch_button_on: got %b expected 0", io.button_on); end
        checks++;
        if (io.dbg_state !== 2'd0) begin errors++; $display("FAIL glitch_state: got %0d expected 0", io.dbg_state); end
    endtask

    task automatic wait_rise(input string tag);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            got = m_rise;
        end
        checks++;
        if (!got || io.button_on !== 1'b1) begin
            errors++; $display("FAIL %s_rise: got button_on=%b expected 1 (accepted=%b)", tag, io.button_on, got);
        end
    endtask

    task automatic test_back_to_back();
        io.btn_raw = 1'b1;
        wait_rise("b2b_first");
        io.btn_rd = 1'b1;
        tick();
        io.btn_rd = 1'b0;
        checks++;
        if (io.button_on !== 1'b0) begin errors++; $display("FAIL b2b_clear: got %b expected 0", io.button_on); end
        io.btn_raw = 1'b0;
        wait_level(1'b0, "b2b_release");
        // Read strobe held across the accepting edge: set must win.
        io.btn_rd  = 1'b1;
        io.btn_raw = 1'b1;
        wait_rise("b2b_set_wins");
        tick();
        io.btn_rd = 1'b0;
        checks++;
        if (io.button_on !== 1'b0) begin errors++; $display("FAIL b2b_clear_after: got %b expected 0", io.button_on); end
    endtask

    // A5C3 held two samples, then A5C2: publication at tick S+5.
    task automatic test_switch_filter();
        logic [15:0] exp_sw;
        io.sw_raw = 16'hA5C3;
        for (int t = 1; t <= S + 7; t++) begin
            if (t == 3) io.sw_raw = 16'hA5C2;
            tick();
            exp_sw = (t >= S + 5) ? 16'hA5C2 : 16'h0000;
            checks++;
            if (io.io_rdata_switch !== exp_sw) begin
                errors++; $display("FAIL switch_filter t=%0d: got %h expected %h", t, io.io_rdata_switch, exp_sw);
            end
            checks++;
            if (io.io_rdata_switch !== m_sw) begin
                errors++; $display("FAIL switch_model t=%0d: got %h expected %h", t, io.io_rdata_switch, m_sw);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        io.btn_raw = 1'b0;
        wait_level(1'b0, "rstmid");
        io.btn_raw = 1'b1;
        repeat (5) tick();
        checks++;
        if (io.dbg_state !== 2'd1) begin errors++; $display("FAIL rstmid_pre_state: got %0d expected 1", io.dbg_state); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (io.button_on !== 1'b0 || io.btn_level !== 1'b0 || io.io_rdata_switch !== 16'h0000 ||
            io.press_count !== 8'd0 || io.dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_async: got on=%b lvl=%b sw=%h pc=%0d st=%0d expected all 0",
                     io.button_on, io.btn_level, io.io_rdata_switch, io.press_count, io.dbg_state);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int t = 1; t <= D + 3; t++) begin
            tick();
            checks++;
            if (io.btn_level !== (t == D + 3) || io.button_on !== (t == D + 3)) begin
                errors++; $display("FAIL rstmid_latency t=%0d: got lvl=%b on=%b expected %b", t, io.btn_level, io.button_on, (t == D + 3));
            end
        end
    endtask

    task automatic test_random();
        int          b_hold;
        int          s_hold;
        logic [15:0] one;
        one    = 16'd1;
        b_hold = 0;
        s_hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (b_hold == 0) begin
                io.btn_raw = 1'($urandom_range(0, 1));
                b_hold = $urandom_range(1, 9);
            end else begin
                b_hold--;
            end
            if (s_hold == 0) begin
                case ($urandom_range(0, 2))
                    0: io.sw_raw = 16'($urandom);
                    1: io.sw_raw = io.sw_raw ^ (one << $urandom_range(0, 15));
                    default: ;
                endcase
                s_hold = $urandom_range(1, 8);
            end else begin
                s_hold--;
            end
            io.btn_rd = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (io.btn_level !== m_level) begin errors++; $display("FAIL rand_level i=%0d: got %b expected %b", i, io.btn_level, m_level); end
            checks++;
            if (io.button_on !== m_on) begin errors++; $display("FAIL rand_button_on i=%0d: got %b expected %b", i, io.button_on, m_on); end
            checks++;
            if (io.io_rdata_switch !== m_sw) begin errors++; $display("FAIL rand_switch i=%0d: got %h expected %h", i, io.io_rdata_switch, m_sw); end
            checks++;
            if (io.press_count !== m_pc) begin errors++; $display("FAIL rand_press_count i=%0d: got %0d expected %0d", i, io.press_count, m_pc); end
        end
        io.btn_rd = 1'b0;
    endtask

    task automatic test_press_wrap();
        logic [7:0] exp_pc;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            io.btn_raw = 1'b1;
            wait_rise("wrap");
`ifdef IO_PRESS_COUNT_EN
            exp_pc = 8'(i + 1);
`else
            exp_pc = 8'd0;
`endif
            checks++;
            if (io.press_count !== exp_pc) begin
                errors++; $display("FAIL wrap_press_count i=%0d: got %0d expected %0d", i, io.press_count, exp_pc);
            end
            io.btn_raw = 1'b0;
            wait_level(1'b0, "wrap");
        end
        checks++;
        if (io.press_count !== 8'd0) begin errors++; $display("FAIL wrap_final: got %0d expected 0", io.press_count); end
    endtask

    initial begin
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_back_to_back();
        test_switch_filter();
        test_reset_mid_debounce();
        test_random();
        test_press_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
